// File: rtl/fb_pkg.sv
// Shared state type, width defaults and master indices for the frame-buffer RAM arbiter.
// Latency: none, types and constants only.
// Backpressure: none, defined by the arbiter that imports this package.
package fb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int DEF_ADDRESS_WIDTH = 6;
  localparam int DEF_DATA_WIDTH    = 10;

  localparam int MST_CPU = 0;
  localparam int MST_LDR = 1;

  localparam int LOCK_CNT_W = 3;

endpackage

// File: rtl/fb_arb_pick.sv
// Two-way grant selector: one-hot grant from the two requests; ptr names the favoured master on a tie.
// Latency: purely combinational.
// Backpressure: a master that loses the tie simply sees no grant.
module fb_arb_pick
  import fb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[MST_CPU] && req[MST_LDR]) begin
      gnt[ptr] = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/fb_ram_arbiter.sv
// Two-master single-port RAM arbiter with bounded lock; FB_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
// Latency: grant and RAM command are combinational in the request cycle; read data and rvalid follow one cycle later.
// Backpressure: an ungranted master holds its request until it sees its grant.
module fb_ram_arbiter
  import fb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int MAX_LOCK      = 4
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     req0,
  input  logic                     we0,
  input  logic                     lock0,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0]    wdata0,
  output logic                     gnt0,
  output logic                     rvalid0,
  output logic [DATA_WIDTH-1:0]    rdata0,

  input  logic                     req1,
  input  logic                     we1,
  input  logic                     lock1,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]    wdata1,
  output logic                     gnt1,
  output logic                     rvalid1,
  output logic [DATA_WIDTH-1:0]    rdata1,

  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic                     ram_wr,
  output logic [DATA_WIDTH-1:0]    ram_wdata,
  input  logic [DATA_WIDTH-1:0]    ram_rdata
);

  arb_state_t            state, state_nxt;
  logic [LOCK_CNT_W-1:0] lock_cnt, lock_cnt_nxt, lock_cnt_inc;
  logic                  lock_room;
  logic [1:0]            req_ok;
  logic [1:0]            gnt;
  logic                  rr_ptr;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

  // The owner is the only eligible master; reset masks everything.
  always_comb begin
    req_ok = 2'b00;
    case (state)
      IDLE:    req_ok = {req1, req0};
      OWN0:    req_ok = {1'b0, req0};
      OWN1:    req_ok = {req1, 1'b0};
      default: req_ok = 2'b00;
    endcase
    if (!rst) begin
      req_ok = 2'b00;
    end
  end

  fb_arb_pick u_pick (
    .req (req_ok),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  assign gnt0 = gnt[MST_CPU];
  assign gnt1 = gnt[MST_LDR];

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wr    = 1'b0;
    if (gnt[MST_CPU]) begin
      ram_addr  = addr0;
      ram_wdata = wdata0;
      ram_wr    = we0;
    end else if (gnt[MST_LDR]) begin
      ram_addr  = addr1;
      ram_wdata = wdata1;
      ram_wr    = we1;
    end
  end

  // Count is zero in IDLE, so the increment also covers the first grant of a lock run.
  assign lock_cnt_inc = (lock_cnt == '1) ? lock_cnt : lock_cnt + LOCK_CNT_W'(1);
  assign lock_room    = int'(lock_cnt_inc) < MAX_LOCK;

  always_comb begin
    state_nxt    = IDLE;
    lock_cnt_nxt = '0;
    if (gnt[MST_CPU] && lock0 && lock_room) begin
      state_nxt    = OWN0;
      lock_cnt_nxt = lock_cnt_inc;
    end else if (gnt[MST_LDR] && lock1 && lock_room) begin
      state_nxt    = OWN1;
      lock_cnt_nxt = lock_cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      lock_cnt <= '0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
      rvalid0  <= gnt[MST_CPU] & ~we0;
      rvalid1  <= gnt[MST_LDR] & ~we1;
      if (rvalid0) begin
        rdata0_q <= ram_rdata;
      end
      if (rvalid1) begin
        rdata1_q <= ram_rdata;
      end
    end
  end

  // RAM data is live only in the rvalid cycle; the held copy covers every other cycle.
  assign rdata0 = rvalid0 ? ram_rdata : rdata0_q;
  assign rdata1 = rvalid1 ? ram_rdata : rdata1_q;

`ifdef FB_ARB_ROUND_ROBIN_EN
  // rr_ptr names the master that was not granted last, so master 0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= 1'b0;
    end else if (gnt[MST_CPU]) begin
      rr_ptr <= 1'b1;
    end else if (gnt[MST_LDR]) begin
      rr_ptr <= 1'b0;
    end
  end
`else
  assign rr_ptr = 1'b0;
`endif

endmodule

// File: tb/tb_fb_ram_arbiter.sv
// Self-checking bench for fb_ram_arbiter: directed scenarios plus random traffic against an ownership/queue model.
module tb_fb_ram_arbiter;

  localparam int AW = 6;
  localparam int DW = 10;
  localparam int ML = 4;
`ifdef FB_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0 = 1'b0, we0 = 1'b0, lock0 = 1'b0;
  logic [AW-1:0] addr0 = '0;
  logic [DW-1:0] wdata0 = '0;
  logic          req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
  logic [AW-1:0] addr1 = '0;
  logic [DW-1:0] wdata1 = '0;
  logic          gnt0, rvalid0, gnt1, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] ram_addr;
  logic          ram_wr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic [DW-1:0] ram [64];

  int errors = 0;
  int checks = 0;

  // Reference model: current owner (-1 none), length of the current grant run, last winner, golden memory.
  int            m_owner, m_run, m_last, g_win;
  logic          m_rv0, m_rv1;
  logic [DW-1:0] m_rd0, m_rd1;
  logic [DW-1:0] gold [64];
  bit            pend0, pend1;

  fb_ram_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(ML)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) ram[i] <= DW'(i * 5 + 1);
    end else if (ram_wr) begin
      ram[ram_addr] <= ram_wdata;
    end
  end

  always @(posedge clk) ram_rdata <= ram[ram_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_run   = 0;
    m_last  = 1;
    m_rv0   = 1'b0;
    m_rv1   = 1'b0;
    m_rd0   = '0;
    m_rd1   = '0;
    for (int i = 0; i < 64; i++) gold[i] = DW'(i * 5 + 1);
  endtask

  // Waits for the falling edge, checks every output against the model, then advances the model.
  task automatic eval_cycle();
    int            win;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          ew;
    @(negedge clk);
    win = -1;
    if (m_owner < 0) begin
      if (req0 && req1) win = RR ? 1 - m_last : 0;
      else if (req0)    win = 0;
      else if (req1)    win = 1;
    end else if (m_owner == 0) begin
      if (req0) win = 0;
    end else begin
      if (req1) win = 1;
    end
    ea = (win == 0) ? addr0  : (win == 1) ? addr1  : '0;
    ed = (win == 0) ? wdata0 : (win == 1) ? wdata1 : '0;
    ew = (win == 0) ? we0    : (win == 1) ? we1    : 1'b0;
    check("gnt0",      32'(gnt0),      32'(win == 0));
    check("gnt1",      32'(gnt1),      32'(win == 1));
    check("ram_addr",  32'(ram_addr),  32'(ea));
    check("ram_wdata", 32'(ram_wdata), 32'(ed));
    check("ram_wr",    32'(ram_wr),    32'(ew));
    check("rvalid0",   32'(rvalid0),   32'(m_rv0));
    check("rvalid1",   32'(rvalid1),   32'(m_rv1));
    check("rdata0",    32'(rdata0),    32'(m_rd0));
    check("rdata1",    32'(rdata1),    32'(m_rd1));

    m_rv0 = (win == 0) && !we0;
    m_rv1 = (win == 1) && !we1;
    if (m_rv0) m_rd0 = gold[addr0];
    if (m_rv1) m_rd1 = gold[addr1];
    if (win == 0 && we0) gold[addr0] = wdata0;
    if (win == 1 && we1) gold[addr1] = wdata1;

    if (win >= 0) begin
      m_run  = (m_owner == win) ? m_run + 1 : 1;
      m_last = win;
      if (((win == 0) ? lock0 : lock1) && m_run < ML) begin
        m_owner = win;
      end else begin
        m_owner = -1;
        m_run   = 0;
      end
    end else begin
      m_owner = -1;
      m_run   = 0;
    end
    g_win = win;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    pend0 = 1'b0;
    pend1 = 1'b0;

    // Reset held with both masters requesting.
    req0 = 1'b1;
    req1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt0",    32'(gnt0),    0);
    check("rst_gnt1",    32'(gnt1),    0);
    check("rst_ram_wr",  32'(ram_wr),  0);
    check("rst_rvalid0", 32'(rvalid0), 0);
    check("rst_rvalid1", 32'(rvalid1), 0);
    next_edge();
    rst = 1'b1;
    model_reset();

    // Contention straight out of reset, no locks.
    for (int i = 0; i < 4; i++) begin
      eval_cycle();
      check("cont_gnt0", 32'(gnt0), RR ? 32'(i % 2 == 0) : 32'd1);
      check("cont_gnt1", 32'(gnt1), RR ? 32'(i % 2 == 1) : 32'd0);
      next_edge();
    end

    // Lock limit with the other master waiting.
    lock0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      eval_cycle();
      if (i < 4) check("lock_gnt0", 32'(gnt0), 1);
      else       check("lock_rel_gnt1", 32'(gnt1), 32'(RR));
      next_edge();
    end
    lock0 = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    eval_cycle();
    next_edge();

    // Master 1 writes then reads address 5.
    req1 = 1'b1; we1 = 1'b1; addr1 = 6'h05; wdata1 = 10'h2A5;
    eval_cycle();
    next_edge();
    we1 = 1'b0;
    eval_cycle();
    check("rd_gnt1", 32'(gnt1), 1);
    next_edge();
    req1 = 1'b0;
    eval_cycle();
    check("rd_rvalid1", 32'(rvalid1), 1);
    check("rd_rdata1",  32'(rdata1),  32'h2A5);
    next_edge();

    // Master 0 write-then-read at the top address.
    req0 = 1'b1; we0 = 1'b1; addr0 = 6'h3F; wdata0 = 10'h3FF;
    eval_cycle();
    check("wr_ram_wr",    32'(ram_wr),    1);
    check("wr_ram_wdata", 32'(ram_wdata), 32'h3FF);
    next_edge();
    we0 = 1'b0;
    eval_cycle();
    next_edge();
    req0 = 1'b0;
    eval_cycle();
    check("wr_rvalid0", 32'(rvalid0), 1);
    check("wr_rdata0",  32'(rdata0),  32'h3FF);
    next_edge();
    eval_cycle();
    check("hold_rvalid0", 32'(rvalid0), 0);
    check("hold_rdata0",  32'(rdata0),  32'h3FF);
    next_edge();

    // Reset lands between a locked read grant and its data cycle.
    req0 = 1'b1; we0 = 1'b0; lock0 = 1'b1; addr0 = 6'h3F;
    eval_cycle();
    check("mr_gnt0", 32'(gnt0), 1);
    #2 rst = 1'b0;
    #1;
    check("mr_gnt0_rst", 32'(gnt0),    0);
    check("mr_rvalid0",  32'(rvalid0), 0);
    @(posedge clk);
    #1;
    check("mr_rvalid0_edge", 32'(rvalid0), 0);
    check("mr_rdata0",       32'(rdata0),  0);
    rst = 1'b1;
    model_reset();
    req0 = 1'b0; lock0 = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 6'h02;
    eval_cycle();
    check("mr_idle_gnt1", 32'(gnt1), 1);
    next_edge();
    req1 = 1'b0;

    // Random traffic; each master holds its request until granted.
    for (int n = 0; n < 3000; n++) begin
      if (!pend0 && $urandom_range(0, 1) == 1) begin
        pend0  = 1'b1;
        we0    = 1'($urandom_range(0, 1));
        addr0  = AW'($urandom_range(0, 7));
        wdata0 = DW'($urandom);
      end
      if (!pend1 && $urandom_range(0, 1) == 1) begin
        pend1  = 1'b1;
        we1    = 1'($urandom_range(0, 1));
        addr1  = AW'($urandom_range(0, 7));
        wdata1 = DW'($urandom);
      end
      req0  = pend0;
      req1  = pend1;
      lock0 = ($urandom_range(0, 2) == 0);
      lock1 = ($urandom_range(0, 2) == 0);
      eval_cycle();
      if (g_win == 0) pend0 = 1'b0;
      if (g_win == 1) pend1 = 1'b0;
      next_edge();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_ram_arbiter.md
FB_RAM_ARBITER -- requirements
Module: fb_ram_arbiter

Interface
REQ-001 Parameters: ADDRESS_WIDTH, default 6, RAM address width; DATA_WIDTH, default 10, RAM word width; MAX_LOCK, default 4, maximum consecutive grants to one locked master.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low: `clk` input 1 rising-edge clock; `rst` input 1 asynchronous active-low reset.
REQ-003 `req0` input 1: master 0 (CPU) access request; `we0` input 1: write when 1, read when 0; `lock0` input 1: request to keep ownership on the next cycle.
REQ-004 `addr0` input ADDRESS_WIDTH: master 0 address; `wdata0` input DATA_WIDTH: master 0 write data.
REQ-005 `gnt0` output 1: master 0 access accepted this cycle; `rvalid0` output 1: read data valid; `rdata0` output DATA_WIDTH: read data.
REQ-006 `req1`, `we1`, `lock1`, `addr1`, `wdata1`, `gnt1`, `rvalid1`, `rdata1`: the same set for master 1 (loader/debug), with identical widths and meanings.
REQ-007 `ram_addr` output ADDRESS_WIDTH, `ram_wr` output 1, `ram_wdata` output DATA_WIDTH: single-port RAM command; `ram_rdata` input DATA_WIDTH: RAM read data, valid one cycle after the address.

Function
REQ-008 The block SHALL grant at most one master per cycle; gntN is combinational from registered state and the current reqN.
REQ-009 When gntN=1, ram_addr=addrN, ram_wdata=wdataN and ram_wr=weN in the same cycle. When neither master is granted, ram_addr=0, ram_wdata=0 and ram_wr=0.
REQ-010 A master SHALL hold reqN, weN, addrN and wdataN stable until it sees gntN=1. A request is consumed in the cycle gntN=1.
REQ-011 A granted read (weN=0) SHALL produce rvalidN=1 in the next cycle, with rdataN=ram_rdata. Otherwise rvalidN=0 and rdataN holds its last value.
REQ-012 FSM states: IDLE, OWN0, OWN1.
  - IDLE: arbitrate per REQ-013.
  - The state moves to OWNn when the granted master has lockN=1 and the lock count is below MAX_LOCK; otherwise it returns to IDLE.
REQ-013 Arbitration in IDLE with a single requester: grant that requester.
REQ-014 Arbitration in IDLE with both requesting: the policy is set by REQ-021.
REQ-015 In OWNn, only master n SHALL be grantable.
  - If reqn=0, no grant is given and the state returns to IDLE.
  - Requests from the other master wait.
REQ-016 Lock counter: 3-bit saturating count of consecutive grants in OWNn.
  - Cleared on entry to IDLE.
  - When the count reaches MAX_LOCK, ownership SHALL be released to IDLE regardless of lockN, giving one forced arbitration.
REQ-017 The lock counter arithmetic SHALL NOT wrap; MAX_LOCK=1 disables locking in effect.
REQ-018 Simultaneous events: a lock release and a new request in the same cycle resolve next cycle in IDLE. A write followed by a read to the same address from the same master returns the new data.

Reset
REQ-019 On rst=0, immediately and asynchronously:
  - the state SHALL go to IDLE;
  - the lock counter, round-robin pointer, rvalid0/1 and rdata0/1 SHALL be cleared to 0.
  - gnt0/1 and ram_wr SHALL be 0 while rst=0.
REQ-020 When reset is asserted mid-operation, the in-flight read SHALL be dropped (no rvalid); the master re-requests after reset.

Configuration
REQ-021 Macro FB_ARB_ROUND_ROBIN_EN selects the policy when both masters request in IDLE.
  - Defined: round-robin. A 1-bit last-grant pointer selects the master not granted last; the pointer updates on every grant.
  - Undefined: fixed priority, master 0 always wins. The pointer is not implemented.

Structure
REQ-022 A shared package `fb_pkg` SHALL hold:
  - the FSM state typedef (IDLE/OWN0/OWN1);
  - ADDRESS_WIDTH/DATA_WIDTH defaults;
  - master index constants.
REQ-023 One sub-module, `fb_arb_pick`, SHALL be the combinational two-way grant selector (reqs, pointer -> one-hot grant); all state SHALL live in fb_ram_arbiter.

Verification
REQ-024 Reset: hold rst=0 with req0=req1=1 -> gnt0=gnt1=0, ram_wr=0, rvalid0/1=0; release -> grant on the first clk edge cycle.
REQ-025 Single read: req1=1, we1=0, addr1=6'h05, RAM[5]=10'h2A5 -> gnt1=1 the same cycle, rvalid1=1 with rdata1=10'h2A5 the next cycle.
REQ-026 Contention: req0=req1=1 for 4 cycles, no locks.
  - With the macro: grants alternate 0,1,0,1.
  - Without it: gnt0 on all 4 cycles, gnt1=0.
REQ-027 Lock limit: MAX_LOCK=4, req0=lock0=1 continuously, req1=1 -> gnt0 for 4 cycles, then one IDLE arbitration cycle where master 1 is granted (round-robin).
REQ-028 Write-then-read: master 0 writes 10'h3FF to addr 6'h3F, then reads 6'h3F -> ram_wr=1 with ram_wdata=10'h3FF, then rvalid0=1 with rdata0=10'h3FF.
REQ-029 Reset mid-read: grant a read to master 0, assert rst=0 before the next edge -> rvalid0 stays 0, state IDLE.
